// File: rtl/alu_pkg.sv
// alu_seq shared types: opcodes, FSM states
// and the shift-op predicate.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_RXOR = 4'd4,
    OP_XOR  = 4'd5,
    OP_NOT  = 4'd6,
    OP_SHL  = 4'd7,
    OP_SHR  = 4'd8
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  function automatic logic is_shift(op_t op);
    return (op == OP_SHL) || (op == OP_SHR);
  endfunction

endpackage

// File: rtl/alu_core.sv
// alu_core: single-cycle ops and operand flags.
// Shift results come from the iterator in alu_seq.
module alu_core
  import alu_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [3:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] rslt,
  output logic         beq,
  output logic         slt,
  output logic         carry,
  output logic         err
);

  logic [W:0] sum;
  logic [W:0] diff;

  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};
  assign beq  = (a == b);
  assign slt  = (a < b);

  // opcode decode; illegal codes saturate to max positive
  always_comb begin
    rslt  = '0;
    carry = 1'b0;
    err   = 1'b0;
    case (op_t'(op))
      OP_ADD: begin
        rslt  = sum[W-1:0];
        carry = sum[W];
      end
      OP_SUB: begin
        rslt  = diff[W-1:0];
        carry = diff[W];
      end
      OP_AND:  rslt = a & b;
      OP_OR:   rslt = a | b;
      OP_RXOR: rslt = {{(W-1){1'b0}}, ^a};
      OP_XOR:  rslt = a ^ b;
      OP_NOT:  rslt = ~a;
      OP_SHL:  rslt = '0;
      OP_SHR:  rslt = '0;
      default: begin
        rslt = {1'b0, {(W-1){1'b1}}};
        err  = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU with a bit-serial
// shifter and registered result/flags.
module alu_seq
  import alu_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   alu_cmd,
  input  logic [W-1:0] inA,
  input  logic [W-1:0] inB,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] rslt,
  output logic         beq,
  output logic         slt,
  output logic         carry,
  output logic         zero,
  output logic         err
);

  localparam int CW = $clog2(W + 1);
  localparam logic [W-1:0] WMAX = W'(W);

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q;
  logic           dir_q;
  logic [W-1:0]   rslt_q;
  logic           beq_q, slt_q, carry_q;
  logic           zero_q, err_q;

  logic [W-1:0]   core_rslt;
  logic           core_beq, core_slt;
  logic           core_carry, core_err;
  logic           accept;
  logic           shift_op;
  logic [CW-1:0]  n_amt;
  logic [W-1:0]   shifted;

  alu_core #(.W(W)) u_core (
    .op    (alu_cmd),
    .a     (inA),
    .b     (inB),
    .rslt  (core_rslt),
    .beq   (core_beq),
    .slt   (core_slt),
    .carry (core_carry),
    .err   (core_err)
  );

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign accept    = in_valid && in_ready;
  assign shift_op  = is_shift(op_t'(alu_cmd));
  assign n_amt     = (inB >= WMAX) ? CW'(W)
                                   : CW'(inB);
  assign shifted   = dir_q ? (rslt_q >> 1)
                           : (rslt_q << 1);

  assign rslt  = rslt_q;
  assign beq   = beq_q;
  assign slt   = slt_q;
  assign carry = carry_q;
  assign zero  = zero_q;
  assign err   = err_q;

  // state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // next-state: shifts with n>0 detour via SHIFT
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (shift_op && (n_amt != '0))
            state_d = S_SHIFT;
          else
            state_d = S_DONE;
        end
      end
      S_SHIFT: begin
        if (cnt_q == CW'(1)) state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // capture at accept, then rslt_q doubles as
  // the shift working register
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      rslt_q  <= '0;
      beq_q   <= 1'b0;
      slt_q   <= 1'b0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (accept) begin
            beq_q   <= core_beq;
            slt_q   <= core_slt;
            carry_q <= core_carry;
            err_q   <= core_err;
            dir_q   <= (op_t'(alu_cmd) == OP_SHR);
            if (shift_op) begin
              rslt_q <= inA;
              cnt_q  <= n_amt;
              zero_q <= (inA == '0);
            end else begin
              rslt_q <= core_rslt;
              cnt_q  <= '0;
              zero_q <= (core_rslt == '0);
            end
          end
        end
        S_SHIFT: begin
          rslt_q <= shifted;
          cnt_q  <= cnt_q - CW'(1);
          zero_q <= (shifted == '0);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed + random transactions on
// W=8 and W=16 instances against a reference model.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sel = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [3:0]  alu_cmd = '0;
  logic [15:0] inA = '0;
  logic [15:0] inB = '0;

  logic        ir8, ov8, beq8, slt8, c8, z8, e8;
  logic [7:0]  r8;
  logic        ir16, ov16, beq16, slt16, c16, z16, e16;
  logic [15:0] r16;

  logic        ir, ov, beq, slt, cy, zf, ef;
  logic [15:0] rs;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  alu_seq #(.W(8)) u8 (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid & ~sel),
    .in_ready  (ir8),
    .alu_cmd   (alu_cmd),
    .inA       (inA[7:0]),
    .inB       (inB[7:0]),
    .out_valid (ov8),
    .out_ready (out_ready),
    .rslt      (r8),
    .beq       (beq8),
    .slt       (slt8),
    .carry     (c8),
    .zero      (z8),
    .err       (e8)
  );

  alu_seq #(.W(16)) u16 (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid & sel),
    .in_ready  (ir16),
    .alu_cmd   (alu_cmd),
    .inA       (inA),
    .inB       (inB),
    .out_valid (ov16),
    .out_ready (out_ready),
    .rslt      (r16),
    .beq       (beq16),
    .slt       (slt16),
    .carry     (c16),
    .zero      (z16),
    .err       (e16)
  );

  assign ir  = sel ? ir16  : ir8;
  assign ov  = sel ? ov16  : ov8;
  assign rs  = sel ? r16   : {8'h00, r8};
  assign beq = sel ? beq16 : beq8;
  assign slt = sel ? slt16 : slt8;
  assign cy  = sel ? c16   : c8;
  assign zf  = sel ? z16   : z8;
  assign ef  = sel ? e16   : e8;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h",
                tag, obs, exp);
  endtask

  function automatic void model(
    input  bit          wide,
    input  logic [3:0]  op,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] r,
    output logic        c,
    output int          lat
  );
    int w;
    int m;
    int ai;
    int bi;
    w  = wide ? 16 : 8;
    m  = (1 << w) - 1;
    ai = int'(a) & m;
    bi = int'(b) & m;
    c   = 1'b0;
    lat = 1;
    case (op)
      4'd0: begin
        r = 16'((ai + bi) & m);
        c = (ai + bi) > m;
      end
      4'd1: begin
        r = 16'((ai - bi) & m);
        c = ai < bi;
      end
      4'd2: r = 16'(ai & bi);
      4'd3: r = 16'(ai | bi);
      4'd4: r = 16'($countones(ai) % 2);
      4'd5: r = 16'(ai ^ bi);
      4'd6: r = 16'(~ai & m);
      4'd7: begin
        r   = (bi >= w) ? 16'h0
                        : 16'((ai << bi) & m);
        lat = 1 + ((bi >= w) ? w : bi);
      end
      4'd8: begin
        r   = (bi >= w) ? 16'h0 : 16'(ai >> bi);
        lat = 1 + ((bi >= w) ? w : bi);
      end
      default: r = 16'(m >> 1);
    endcase
  endfunction

  task automatic run(input bit          wide,
                     input logic [3:0]  op,
                     input logic [15:0] a,
                     input logic [15:0] b,
                     input int          hold,
                     input bit          use_lit,
                     input logic [15:0] lit);
    logic [15:0] er;
    logic        ec;
    int          elat;
    int          edges;
    int          busy_bad;
    int          hold_bad;
    logic [15:0] m;
    logic [20:0] snap;
    int          t;
    m  = wide ? 16'hFFFF : 16'h00FF;
    model(wide, op, a & m, b & m, er, ec, elat);
    @(negedge clk);
    sel = wide;
    t = 0;
    while (!ir && t < 40) begin
      @(negedge clk);
      t++;
    end
    chk("in_ready_idle", 32'(ir), 32'd1);
    in_valid  = 1'b1;
    alu_cmd   = op;
    inA       = a & m;
    inB       = b & m;
    out_ready = (hold == 0);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    inA = 16'($urandom);
    inB = 16'($urandom);
    alu_cmd = 4'($urandom);
    edges = 1;
    busy_bad = 0;
    while (!ov && edges < 40) begin
      if (ir) busy_bad++;
      @(negedge clk);
      edges++;
    end
    chk("latency", 32'(edges), 32'(elat));
    chk("busy_in_ready", 32'(busy_bad + int'(ir)),
        32'd0);
    chk("rslt", 32'(rs), 32'(er));
    if (use_lit) chk("rslt_lit", 32'(rs), 32'(lit));
    chk("beq", 32'(beq), 32'((a & m) == (b & m)));
    chk("slt", 32'(slt), 32'((a & m) < (b & m)));
    chk("carry", 32'(cy), 32'(ec));
    chk("zero", 32'(zf), 32'(er == 16'h0));
    chk("err", 32'(ef), 32'(op > 4'd8));
    snap = {rs, beq, slt, cy, zf, ef};
    hold_bad = 0;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      alu_cmd  = 4'($urandom);
      inA      = 16'($urandom);
      inB      = 16'($urandom);
      @(negedge clk);
      if ({rs, beq, slt, cy, zf, ef} !== snap)
        hold_bad++;
      if (ov !== 1'b1 || ir !== 1'b0)
        hold_bad++;
    end
    if (hold > 0) chk("hold_stable", 32'(hold_bad), 32'd0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("post_xfer_valid", 32'(ov), 32'd0);
    chk("post_xfer_ready", 32'(ir), 32'd1);
  endtask

  initial begin
    int bad;
    logic [3:0]  op;
    logic [15:0] a, b;
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(ov8), 32'd0);
    chk("rst_rslt", 32'(r8), 32'd0);
    chk("rst_flags",
        32'({beq8, slt8, c8, z8, e8}), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_ready", 32'(ir8), 32'd1);
    chk("rst_ready16", 32'(ir16), 32'd1);

    run(0, 4'd0, 16'hF0, 16'h20, 0, 1, 16'h10);
    run(0, 4'd1, 16'h05, 16'h05, 0, 1, 16'h00);
    run(0, 4'd1, 16'h03, 16'h07, 0, 1, 16'hFC);
    run(0, 4'd7, 16'h81, 16'd3, 0, 1, 16'h08);
    run(0, 4'd8, 16'h81, 16'd0, 0, 1, 16'h81);
    run(0, 4'd8, 16'h81, 16'd200, 0, 1, 16'h00);
    run(0, 4'd7, 16'h81, 16'd8, 0, 1, 16'h00);
    run(1, 4'd4, 16'h0007, 16'h0, 0, 1, 16'h0001);
    run(1, 4'd6, 16'h00FF, 16'h0, 0, 1, 16'hFF00);
    run(1, 4'hC, 16'h1234, 16'h5, 0, 1, 16'h7FFF);
    run(1, 4'd8, 16'h8001, 16'd15, 0, 1, 16'h0001);
    run(0, 4'd0, 16'h3C, 16'h11, 5, 1, 16'h4D);

    @(negedge clk);
    sel = 1'b0;
    in_valid = 1'b1;
    alu_cmd  = 4'd7;
    inA      = 16'h01;
    inB      = 16'd6;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_valid", 32'(ov8), 32'd0);
    chk("midrst_rslt", 32'(r8), 32'd0);
    chk("midrst_flags",
        32'({beq8, slt8, c8, z8, e8}), 32'd0);
    chk("midrst_ready", 32'(ir8), 32'd1);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ov8 !== 1'b0) bad++;
    end
    chk("midrst_no_emit", 32'(bad), 32'd0);

    for (int i = 0; i < 60; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = 16'($urandom);
      b  = 16'($urandom);
      if ((op == 4'd7 || op == 4'd8) &&
          $urandom_range(0, 3) != 0)
        b = 16'($urandom_range(0, 17));
      if ($urandom_range(0, 4) == 0) b = a;
      run(bit'(i % 2), op, a, b,
          int'($urandom_range(0, 2)), 0, 16'h0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, handshaked ALU; next generation of the team's 8-bit combinational ALU.
- Accepts one operation per transaction on a valid/ready input port and returns a registered result plus flags on a valid/ready output port.
- Simple ops finish in 1 cycle. Shifts iterate one bit position per cycle, so a small datapath can support wide operands.
- Sits between the register file read stage and the writeback stage of the processor datapath.

Parameters:
- W, 8: operand/result width in bits (W >= 2).
- CW, $clog2(W+1): shift-counter width (derived; not overridden).

Ports:
- clk, input, 1: sole clock; all state updates on its rising edge.
- reset, input, 1: synchronous, active-high reset.
- in_valid, input, 1: operation request.
- in_ready, output, 1: block can accept a request.
- alu_cmd, input, 4: opcode (alu_pkg::op_t).
- inA, input, W: operand A.
- inB, input, W: operand B; shift amount for SHL/SHR.
- out_valid, output, 1: result/flags valid.
- out_ready, input, 1: consumer accepts the result.
- rslt, output, W: result.
- beq, output, 1: inA == inB, captured at accept.
- slt, output, 1: inA < inB unsigned, captured at accept.
- carry, output, 1: ADD carry-out, or SUB borrow; 0 for all other ops.
- zero, output, 1: rslt == 0.
- err, output, 1: illegal opcode was issued.

Behaviour:
- Reset: state IDLE. out_valid=0, rslt=0, beq=0, slt=0, carry=0, zero=0, err=0, shift counter=0. in_ready=1 from the first cycle after reset.
- A reset asserted mid-operation aborts a shift in progress or a held result; nothing is emitted.
- Opcodes and results:
  - ADD 0: rslt = inA+inB, mod 2^W.
  - SUB 1: rslt = inA-inB, mod 2^W.
  - AND 2: rslt = inA & inB.
  - OR 3: rslt = inA | inB.
  - RXOR 4: rslt = {W-1 zeros, ^inA}.
  - XOR 5: rslt = inA ^ inB.
  - NOT 6: rslt = ~inA, bitwise.
  - SHL 7: logical left shift of inA by inB.
  - SHR 8: logical right shift of inA by inB.
  - Codes 9-15: illegal. rslt = {1'b0, W-1 ones}, err=1, 1-cycle latency.
- Handshake:
  - Accept occurs when in_valid && in_ready.
  - in_ready = (state == IDLE).
  - Output transfer occurs when out_valid && out_ready.
  - rslt and all flags hold stable while out_valid=1 and out_ready=0.
  - Operands and opcode are sampled only on the accept cycle; later input changes have no effect.
- FSM:
  - IDLE: on accept of a non-shift op, register the result and flags, then go to DONE.
  - IDLE: on accept of SHL/SHR, load the working register with inA and counter n = min(inB, W).
    - If n == 0, go to DONE with rslt = inA.
    - Otherwise go to SHIFT.
  - SHIFT: each cycle, shift the working register by one bit (zero fill) and decrement the counter. When the counter reaches 1, that cycle's shift is the last; go to DONE.
  - DONE: out_valid=1. On a transfer, go to IDLE; in_ready rises the following cycle.
- Latency, with the accept at edge t:
  - Non-shift op: out_valid=1 after edge t+1.
  - Shift: out_valid=1 after edge t+1+n, where n = min(inB, W).
  - Shift amount inB >= W: result 0 after W shift cycles.
- Flags:
  - beq, slt, carry and err are computed from the operands sampled at accept.
  - zero is computed from the final rslt.
  - carry is bit W of the (W+1)-bit sum or difference.
- Back-to-back: the minimum per-op spacing is 2 cycles (IDLE -> DONE -> IDLE). No accept is taken in the cycle that a transfer completes.

Decomposition:
- Package alu_pkg:
  - typedef enum logic[3:0] op_t: OP_ADD, OP_SUB, OP_AND, OP_OR, OP_RXOR, OP_XOR, OP_NOT, OP_SHL, OP_SHR.
  - typedef enum state_t: S_IDLE, S_SHIFT, S_DONE.
  - Function is_shift(op_t).
- Sub-module alu_core #(W): purely combinational single-cycle ops plus flags (beq/slt/carry/err). alu_seq instantiates it and adds the FSM, shift iterator and output registers.

Test Plan:
- W=8, ADD 8'hF0 + 8'h20, out_ready=1 -> rslt=8'h10, carry=1, beq=0, slt=0, zero=0; out_valid exactly 1 cycle after accept.
- W=8, SUB 8'h05 - 8'h05 -> rslt=0, zero=1, beq=1, carry=0. Then SUB 8'h03 - 8'h07 -> rslt=8'hFC, carry=1, slt=1.
- W=8, SHL 8'h81 by 3 -> rslt=8'h08 after 4 cycles; in_ready=0 throughout. SHR 8'h81 by 0 -> rslt=8'h81 after 1 cycle. SHR by 8'd200 -> rslt=0 after 9 cycles.
- W=16:
  - RXOR 16'h0007 -> rslt=16'h0001.
  - NOT 16'h00FF -> 16'hFF00.
  - Opcode 4'hC -> rslt=16'h7FFF, err=1.
- Backpressure: hold out_ready=0 for 5 cycles after result; change inA/inB/in_valid meanwhile -> rslt/flags stable, in_ready=0, no second accept.
- Reset mid-shift: SHL 8'h01 by 6, assert reset on cycle 3 -> all outputs 0, out_valid never asserts for that op, in_ready=1 the cycle after reset deasserts.
